// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one request per handshake, a held mem strobe for ACCESS_CYCLES
// cycles, then an extended-load / misalign response held until WBU accepts it.
module lsu_mem_ctrl #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] mem_raddr,
  output logic        mem_read,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_write
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  off;
  logic [1:0]  size;
  logic        uns;
  logic        wen;
  logic        accept;
  logic        misalign;
  logic [7:0]  base;
  logic [63:0] sh;
  logic [63:0] ext;

  assign accept = req_valid & req_ready;

  always_comb begin
    misalign = 1'b0;
    base     = 8'h01;
    case (req_size)
      2'd0: begin misalign = 1'b0;              base = 8'h01; end
      2'd1: begin misalign = req_addr[0];       base = 8'h03; end
      2'd2: begin misalign = |req_addr[1:0];    base = 8'h0F; end
      default: begin misalign = |req_addr[2:0]; base = 8'hFF; end
    endcase
  end

  // Load extraction works off the registered offset/size so it only depends on mem_rdata.
  always_comb begin
    sh  = mem_rdata >> {off, 3'b000};
    ext = sh;
    case (size)
      2'd0: ext = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1: ext = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2: ext = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      off           <= '0;
      size          <= '0;
      uns           <= 1'b0;
      wen           <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      mem_raddr     <= '0;
      mem_read      <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      mem_write     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_ready  <= 1'b0;
          off        <= req_addr[2:0];
          size       <= req_size;
          uns        <= req_unsigned;
          wen        <= req_wen;
          cnt        <= '0;
          resp_rdata <= '0;
          if (misalign) begin
            // No memory access for misaligned requests; straight to the response.
            resp_misalign <= 1'b1;
            resp_valid    <= 1'b1;
            state         <= RESP;
          end else begin
            resp_misalign <= 1'b0;
            mem_read      <= ~req_wen;
            mem_write     <= req_wen;
            state         <= ACCESS;
            if (req_wen) begin
              mem_waddr <= {req_addr[63:3], 3'b000};
              mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              mem_wmask <= base << req_addr[2:0];
            end else begin
              mem_raddr <= {req_addr[63:3], 3'b000};
            end
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= wen ? 64'd0 : ext;
            state      <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid    <= 1'b0;
          resp_misalign <= 1'b0;
          req_ready     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench: one instance with single-cycle access, one with three-cycle access
// for the mid-access reset scenario. Inputs are shared; each instance has its own reset.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, rst_n3;
  logic        req_valid, req_wen, req_unsigned, resp_ready;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [1:0]  req_size;

  logic        req_ready, resp_valid, resp_misalign, mem_read, mem_write;
  logic [63:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  logic        req_ready_3, resp_valid_3, resp_misalign_3, mem_read_3, mem_write_3;
  logic [63:0] resp_rdata_3, mem_raddr_3, mem_waddr_3, mem_wdata_3;
  logic [7:0]  mem_wmask_3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ACCESS_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_raddr(mem_raddr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_write(mem_write)
  );

  lsu_mem_ctrl #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n3),
    .req_valid(req_valid), .req_ready(req_ready_3), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid_3), .resp_ready(resp_ready), .resp_rdata(resp_rdata_3),
    .resp_misalign(resp_misalign_3),
    .mem_raddr(mem_raddr_3), .mem_read(mem_read_3), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr_3), .mem_wdata(mem_wdata_3), .mem_wmask(mem_wmask_3),
    .mem_write(mem_write_3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request and let it be taken at the next edge.
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_n3 = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 0; resp_ready = 0; mem_rdata = '0;
    tick(); tick();

    // reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_raddr", mem_raddr, 64'd0);
    check("rst_wmask", 64'(mem_wmask), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: LD aligned
    mem_rdata = 64'h1122334455667788;
    issue(1'b0, 64'h80000008, 64'd0, 2'd3, 1'b0);
    check("ld_read_n1", 64'(mem_read), 64'd1);
    check("ld_raddr", mem_raddr, 64'h80000008);
    check("ld_write_n1", 64'(mem_write), 64'd0);
    check("ld_rv_n1", 64'(resp_valid), 64'd0);
    check("ld_rdy_n1", 64'(req_ready), 64'd0);
    tick();
    check("ld_read_n2", 64'(mem_read), 64'd0);
    check("ld_rv_n2", 64'(resp_valid), 64'd1);
    check("ld_rdata", resp_rdata, 64'h1122334455667788);
    check("ld_misalign", 64'(resp_misalign), 64'd0);
    resp_ready = 1'b1;
    tick();
    check("ld_rv_done", 64'(resp_valid), 64'd0);
    check("ld_rdy_done", 64'(req_ready), 64'd1);
    resp_ready = 1'b0;

    // 2: LB / LBU at byte offset 5 (byte lane 5 holds 0xAA)
    mem_rdata = 64'h0000AA0000000000;
    issue(1'b0, 64'h80000005, 64'd0, 2'd0, 1'b0);
    check("lb_raddr", mem_raddr, 64'h80000000);
    tick();
    check("lb_rdata", resp_rdata, 64'hFFFFFFFFFFFFFFAA);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    issue(1'b0, 64'h80000005, 64'd0, 2'd0, 1'b1);
    tick();
    check("lbu_rdata", resp_rdata, 64'h00000000000000AA);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;

    // 3: SH at offset 6
    issue(1'b1, 64'h80000006, 64'h000000000000BEEF, 2'd1, 1'b0);
    check("sh_write_n1", 64'(mem_write), 64'd1);
    check("sh_read_n1", 64'(mem_read), 64'd0);
    check("sh_waddr", mem_waddr, 64'h80000000);
    check("sh_wmask", 64'(mem_wmask), 64'hC0);
    check("sh_wdata_hi", 64'(mem_wdata[63:48]), 64'hBEEF);
    tick();
    check("sh_write_n2", 64'(mem_write), 64'd0);
    check("sh_rv", 64'(resp_valid), 64'd1);
    check("sh_rdata", resp_rdata, 64'd0);
    check("sh_misalign", 64'(resp_misalign), 64'd0);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;

    // 4: LW misaligned
    issue(1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0);
    check("mis_rv_n1", 64'(resp_valid), 64'd1);
    check("mis_flag", 64'(resp_misalign), 64'd1);
    check("mis_rdata", resp_rdata, 64'd0);
    check("mis_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    check("mis_strobes_after", {62'd0, mem_read, mem_write}, 64'd0);

    // 5: LW at offset 4, response held off for 5 cycles with a new request pending
    mem_rdata = 64'h8000000012345678;
    issue(1'b0, 64'h80000004, 64'd0, 2'd2, 1'b0);
    tick();
    mem_rdata = 64'h00000000F00D0000;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000002;
    req_size = 2'd1; req_unsigned = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_rv", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata, 64'hFFFFFFFF80000000);
      check("hold_rdy", 64'(req_ready), 64'd0);
      check("hold_read", 64'(mem_read), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("hold_rdy_back", 64'(req_ready), 64'd1);
    check("hold_no_read", 64'(mem_read), 64'd0);
    tick();
    req_valid = 1'b0;
    check("next_read", 64'(mem_read), 64'd1);
    check("next_raddr", mem_raddr, 64'h80000000);
    tick();
    check("lhu_rdata", resp_rdata, 64'h000000000000F00D);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;

    // 6: reset during a 3-cycle access on the second instance
    rst_n = 1'b0; rst_n3 = 1'b1;
    mem_rdata = 64'hCAFEBABE00000000;
    tick();
    issue(1'b0, 64'h80000010, 64'd0, 2'd3, 1'b0);
    check("r3_read_c1", 64'(mem_read_3), 64'd1);
    tick();
    check("r3_read_c2", 64'(mem_read_3), 64'd1);
    #2 rst_n3 = 1'b0;
    #1;
    check("r3_read_async", 64'(mem_read_3), 64'd0);
    check("r3_rdy_async", 64'(req_ready_3), 64'd1);
    tick();
    check("r3_rv_after", 64'(resp_valid_3), 64'd0);
    rst_n3 = 1'b1;
    tick();
    issue(1'b0, 64'h80000010, 64'd0, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("r3_read_run", 64'(mem_read_3), 64'd1);
      check("r3_rv_run", 64'(resp_valid_3), 64'd0);
      tick();
    end
    check("r3_read_end", 64'(mem_read_3), 64'd0);
    check("r3_rv", 64'(resp_valid_3), 64'd1);
    check("r3_rdata", resp_rdata_3, 64'hCAFEBABE00000000);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;

    // SB at the top byte lane
    issue(1'b1, 64'h80000017, 64'h00000000000000A5, 2'd0, 1'b0);
    check("sb_wmask", 64'(mem_wmask_3), 64'h80);
    check("sb_wdata_hi", 64'(mem_wdata_3[63:56]), 64'hA5);
    check("sb_waddr", mem_waddr_3, 64'h80000010);
    tick(); tick(); tick();
    check("sb_rv", 64'(resp_valid_3), 64'd1);
    check("sb_write_end", 64'(mem_write_3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
